// File: rtl/multicycle_control_unit.sv
// Purpose : multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I subset, with a
//           memory req/ready handshake and timeout, a sticky trap state and a retire counter.
// Latency : strobes combinational from state/IR/zero/mem_ready; state and counters registered.
//           With zero-wait memory: R/I/SW 4 cycles, LW 5, branch/JAL 3.
// Backpressure: FETCH and MEM hold mem_req (and the read/write strobe) until mem_ready.
//           After MEM_TIMEOUT cycles without mem_ready the unit traps (0 disables the timeout).
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   instruction     IR contents, stable from DECODE until the next FETCH
//   zero            ALU zero flag, only looked at in EXEC
//   mem_ready       memory completes the pending request this cycle
//   mem_req         memory request valid (FETCH, MEM)
//   ir_write        load IR from memory data
//   pcwrite, pcsrc  PC update enable; select 0: PC+4, 1: branch/jump target
//   aluop, alusrc   ALU operation; operand B select 0: rs2, 1: immediate
//   memtoread       memory read strobe
//   memwrite        memory write strobe
//   memtoreg        writeback source 1: memory, 0: ALU/link
//   regwrite        register file write enable
//   state           FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   illegal         high while trapped (the trap is only left through reset)
//   instret         retired-instruction count, wraps

module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               ir_write,
    output logic               pcwrite,
    output logic               pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrc,
    output logic               memtoread,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regwrite,
    output logic [2:0]         state,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(8);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Wait counter must be able to hold MEM_TIMEOUT itself.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q;

    // ------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE onward)
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_i, is_lw, is_sw, is_br, is_jal, legal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_fields;
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    always_comb begin
        is_r   = 1'b0;
        is_i   = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_br  = 1'b0;
        is_jal = 1'b0;
        case (opcode)
            OP_R:   is_r   = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            OP_I:   is_i   = 1'b1;
            OP_LW:  is_lw  = (funct3 == 3'b010);
            OP_SW:  is_sw  = (funct3 == 3'b010);
            OP_BR:  is_br  = (funct3 == 3'b000) || (funct3 == 3'b001);
            OP_JAL: is_jal = 1'b1;
            default: ;
        endcase
    end

    assign legal = is_r | is_i | is_lw | is_sw | is_br | is_jal;

    // funct3 -> ALU op. instruction[30] selects SUB (R-type only, since on
    // ADDI it is an immediate bit) and SRA/SRAI. The ALU has no unsigned
    // compare, so SLTU/SLTIU share the SLT encoding.
    function automatic logic [ALUOP_W-1:0] alu_decode(input logic [2:0] f3,
                                                      input logic       alt,
                                                      input logic       allow_sub);
        logic [ALUOP_W-1:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLT;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    logic               mem_req_c, ir_write_c, pcwrite_c, pcsrc_c, alusrc_c;
    logic               memtoread_c, memwrite_c, memtoreg_c, regwrite_c;
    logic [ALUOP_W-1:0] aluop_c;
    logic               timed_out, br_taken;

    // Trap once the counter has reached the limit and memory still is not ready.
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == TIMEOUT_V) && !mem_ready;
    // funct3[0]=0: BEQ, 1: BNE
    assign br_taken  = funct3[0] ? !zero : zero;

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        ir_write_c  = 1'b0;
        pcwrite_c   = 1'b0;
        pcsrc_c     = 1'b0;
        alusrc_c    = 1'b0;
        memtoread_c = 1'b0;
        memwrite_c  = 1'b0;
        memtoreg_c  = 1'b0;
        regwrite_c  = 1'b0;
        aluop_c     = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                mem_req_c   = 1'b1;
                memtoread_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pcwrite_c  = 1'b1;
                    state_d    = ST_DECODE;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                state_d = legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                if (is_r) begin
                    aluop_c = alu_decode(funct3, instruction[30], 1'b1);
                    state_d = ST_WB;
                end else if (is_i) begin
                    alusrc_c = 1'b1;
                    aluop_c  = alu_decode(funct3, instruction[30], 1'b0);
                    state_d  = ST_WB;
                end else if (is_lw || is_sw) begin
                    alusrc_c = 1'b1;
                    state_d  = ST_MEM;
                end else if (is_br) begin
                    aluop_c = ALU_SUB;
                    if (br_taken) begin
                        pcwrite_c = 1'b1;
                        pcsrc_c   = 1'b1;
                    end
                    state_d = ST_FETCH;
                end else begin
                    // JAL: link (PC+4) written through the ALU/link path
                    pcwrite_c  = 1'b1;
                    pcsrc_c    = 1'b1;
                    regwrite_c = 1'b1;
                    state_d    = ST_FETCH;
                end
            end

            ST_MEM: begin
                mem_req_c   = 1'b1;
                memtoread_c = is_lw;
                memwrite_c  = is_sw;
                if (mem_ready) begin
                    state_d = is_lw ? ST_WB : ST_FETCH;
                end else if (timed_out) begin
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                regwrite_c = 1'b1;
                memtoreg_c = is_lw;
                state_d    = ST_FETCH;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Wait counter: restarts on any state change and whenever memory answers;
    // saturates so an untimed (MEM_TIMEOUT=0) wait never wraps into a match.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req_c) begin
            if (mem_ready)
                wait_d = '0;
            else if (wait_q != {WAIT_W{1'b1}})
                wait_d = wait_q + WAIT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            // Only EXEC (branch/JAL), MEM (SW) and WB ever return to FETCH.
            if (state_d == ST_FETCH && state_q != ST_FETCH)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes forced low while reset is asserted so an access in
    // flight is dropped immediately rather than on the next edge.
    // ------------------------------------------------------------------
    assign mem_req   = rst_n & mem_req_c;
    assign ir_write  = rst_n & ir_write_c;
    assign pcwrite   = rst_n & pcwrite_c;
    assign pcsrc     = rst_n & pcsrc_c;
    assign alusrc    = rst_n & alusrc_c;
    assign memtoread = rst_n & memtoread_c;
    assign memwrite  = rst_n & memwrite_c;
    assign memtoreg  = rst_n & memtoreg_c;
    assign regwrite  = rst_n & regwrite_c;
    assign aluop     = rst_n ? aluop_c : ALU_ADD;
    assign state     = state_q;
    assign illegal   = (state_q == ST_TRAP);
    assign instret   = instret_q;

endmodule
